cpu_trace_buffer: RTL
=====================

Name: cpu_trace_buffer

Overview:
- Hardware successor to the per-cycle processor monitor: captures one trace record per clock (PC word index, instruction, register-file write) from the single-cycle core into an on-chip FIFO.
- Generalised in record width, FIFO depth and cycle-limit width.
- Adds behaviour the software monitor lacks: a PC breakpoint, a programmable cycle limit that raises a halt request to the core, overflow detection, and a valid/ready readout port for a debug host.
- Sits beside the core at top level; taps pcOut[13:2], the fetched instruction and the register-file write port.

Parameters:
PC_W, 12, PC word-index width (pcOut[13:2])
DATA_W, 32, instruction and register data width
DEPTH, 16, FIFO entries; power of two, at least 2
CYC_W, 16, cycle counter and cycle limit width

Ports:
clk  in  1  core clock; all state on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
trace_en  in  1  arm/run tracing
halt_cycles  in  CYC_W  cycle limit; 0 = unlimited
bp_en  in  1  breakpoint enable
bp_pc  in  PC_W  breakpoint PC word index
pc_in  in  PC_W  current PC word index
instr_in  in  DATA_W  instruction at pc_in
rf_we  in  1  register-file write enable this cycle
rf_waddr  in  5  register write address
rf_wdata  in  DATA_W  register write data
rd_ready  in  1  host accepts head record
rd_valid  out  1  FIFO non-empty
rd_cycle  out  CYC_W  head record cycle index
rd_pc  out  PC_W  head record PC
rd_instr  out  DATA_W  head record instruction
rd_we  out  1  head record write flag
rd_waddr  out  5  head record write address
rd_wdata  out  DATA_W  head record write data
count  out  clog2(DEPTH+1)  entries held
overflow  out  1  sticky: a record was dropped
halt_req  out  1  high in HALTED; core stalls PC
busy  out  1  high in RUN

Behaviour:
- Reset (reset=0, async): state IDLE, FIFO empty, count=0, cycle counter=0. Outputs: rd_valid=0, overflow=0, halt_req=0, busy=0. All rd_* data outputs are 0.
- FSM IDLE -> RUN when trace_en=1. The cycle counter clears to 0 on this transition. No record is captured in the IDLE cycle.
- In RUN with trace_en=1, every cycle pushes one record {cycle, pc_in, instr_in, rf_we, rf_waddr, rf_wdata}, then increments the cycle counter.
- The cycle counter saturates at all-ones and does not wrap.
- RUN -> IDLE when trace_en=0. No capture that cycle.
- RUN -> HALTED after capturing a record when either condition holds:
  - bp_en=1 and pc_in==bp_pc, or
  - halt_cycles!=0 and the captured cycle == halt_cycles-1.
- When both halt conditions hold together, the result is a single HALTED entry; the record is still captured once.
- HALTED: halt_req=1, no capture. HALTED -> IDLE when trace_en=0. Re-arming restarts the cycle count from 0.
- FIFO timing:
  - Push is visible on rd_valid the next cycle (1-cycle latency).
  - Readout is first-word-fall-through; the rd_* outputs show the head record while rd_valid=1.
  - Pop happens on rd_valid & rd_ready.
- Full FIFO with a push and no pop: the record is dropped and overflow is set to 1. overflow stays set until reset.
- Full FIFO with push and pop in the same cycle: both succeed; count is unchanged and overflow is unaffected.
- Empty FIFO with a push in the same cycle as rd_ready=1: no pop; the record appears next cycle.
- Pointers wrap modulo DEPTH. count = entries held, range 0..DEPTH.
- Reset asserted mid-RUN or mid-HALTED: immediate return to IDLE, FIFO flushed, halt_req drops asynchronously.
- The FIFO contents persist across IDLE/RUN/HALTED transitions; only reset flushes them.

Test Plan:
- Reset, trace_en=1, halt_cycles=5, pc_in stepping 0..6, rd_ready=0 -> exactly 5 records, cycles 0..4 with PCs 0..4. halt_req=1 from the cycle after PC 4; count=5; overflow=0.
- bp_en=1, bp_pc=3, halt_cycles=0, PC stepping 0.. -> 4 records (PC 0..3), then HALTED with halt_req=1. A capture at PC 3 with halt_cycles=4 also yields a single halt.
- DEPTH=16, halt_cycles=20, rd_ready=0 -> count=16, overflow=1, head rd_cycle=0. Drain with rd_ready=1 -> 16 pops, cycles 0..15 in order, then rd_valid=0.
- FIFO full with rd_ready=1 held during RUN -> one push and one pop per cycle, count stays 16, overflow stays 0.
- Record with rf_we=1, rf_waddr=3, rf_wdata=30, instr_in=0x00221820 -> read back with identical fields.
- Assert reset=0 mid-RUN with count=7 -> count=0, rd_valid=0, halt_req=0, busy=0 without waiting for a clock edge. After release, trace_en=1 restarts from cycle 0.

Source files
------------

// File: rtl/cpu_trace_buffer.sv
// Per-cycle trace capture for the single-cycle core: records PC, instruction and
// register-file write into a FWFT FIFO, with breakpoint / cycle-limit halt requests.
module cpu_trace_buffer #(
   parameter int PC_W   = 12,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 16,
   parameter int CYC_W  = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       trace_en,
   input  logic [CYC_W-1:0]           halt_cycles,
   input  logic                       bp_en,
   input  logic [PC_W-1:0]            bp_pc,
   input  logic [PC_W-1:0]            pc_in,
   input  logic [DATA_W-1:0]          instr_in,
   input  logic                       rf_we,
   input  logic [4:0]                 rf_waddr,
   input  logic [DATA_W-1:0]          rf_wdata,
   input  logic                       rd_ready,
   output logic                       rd_valid,
   output logic [CYC_W-1:0]           rd_cycle,
   output logic [PC_W-1:0]            rd_pc,
   output logic [DATA_W-1:0]          rd_instr,
   output logic                       rd_we,
   output logic [4:0]                 rd_waddr,
   output logic [DATA_W-1:0]          rd_wdata,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       halt_req,
   output logic                       busy
);
   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int REC_W = CYC_W + PC_W + 2*DATA_W + 6;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALTED} state_t;

   state_t            state_q, state_d;
   logic [CYC_W-1:0]  cyc_q, cyc_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic [REC_W-1:0]  mem_q [DEPTH];

   logic              capture, halt_hit, empty, full, pop, push_ok;
   logic [REC_W-1:0]  rec_in, head;
   logic [CYC_W-1:0]  h_cyc;
   logic [PC_W-1:0]   h_pc;
   logic [DATA_W-1:0] h_instr, h_wdata;
   logic              h_we;
   logic [4:0]        h_waddr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cyc_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cyc_q    <= cyc_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
      end
   end

   // The halt decision uses the cycle index of the record being captured.
   assign halt_hit = (bp_en && (pc_in == bp_pc)) ||
                     ((halt_cycles != '0) && (cyc_q == halt_cycles - CYC_W'(1)));

   always_comb begin
      state_d = state_q;
      cyc_d   = cyc_q;
      case (state_q)
         S_IDLE: begin
            if (trace_en) begin
               state_d = S_RUN;
               cyc_d   = '0;
            end
         end
         S_RUN: begin
            if (!trace_en) begin
               state_d = S_IDLE;
            end else begin
               if (cyc_q != '1) cyc_d = cyc_q + CYC_W'(1);
               if (halt_hit) state_d = S_HALTED;
            end
         end
         S_HALTED: begin
            if (!trace_en) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_q == S_RUN);
      halt_req = (state_q == S_HALTED);
      capture  = (state_q == S_RUN) && trace_en;
   end

   assign empty   = (cnt_q == '0);
   assign full    = (cnt_q == CNT_W'(DEPTH));
   assign pop     = !empty && rd_ready;
   // A full FIFO still accepts a record when the head leaves in the same cycle.
   assign push_ok = capture && (!full || pop);
   assign rec_in  = {cyc_q, pc_in, instr_in, rf_we, rf_waddr, rf_wdata};

   always_comb begin
      wr_ptr_d = push_ok ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = pop     ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
      ovf_d    = ovf_q | (capture & full & ~pop);
      cnt_d    = cnt_q;
      if (push_ok && !pop)      cnt_d = cnt_q + CNT_W'(1);
      else if (!push_ok && pop) cnt_d = cnt_q - CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= rec_in;
   end

   assign head = mem_q[rd_ptr_q];
   assign {h_cyc, h_pc, h_instr, h_we, h_waddr, h_wdata} = head;

   // Record fields are forced to zero while the FIFO is empty.
   assign rd_valid = !empty;
   assign rd_cycle = rd_valid ? h_cyc   : '0;
   assign rd_pc    = rd_valid ? h_pc    : '0;
   assign rd_instr = rd_valid ? h_instr : '0;
   assign rd_we    = rd_valid ? h_we    : 1'b0;
   assign rd_waddr = rd_valid ? h_waddr : '0;
   assign rd_wdata = rd_valid ? h_wdata : '0;
   assign count    = cnt_q;
   assign overflow = ovf_q;

endmodule
